vect_mem_dma: RTL and testbench

//  Initiator for the 48-bit vector data memory port (WE, A, WD, RD): moves blocks of

---
 rtl/vect_mem_dma.sv | 148 ++++++++++++++
 tb/tb_vect_mem_dma.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vect_mem_dma.sv
// vect_mem_dma
//   Block mover for the 48-bit vector data memory port. It takes the memory port
//   while busy. COPY mode reads each source vector and then writes it to the
//   destination. FILL mode writes a constant vector to each destination slot.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     start           job request, sampled only in IDLE
//     mode            0 = COPY, 1 = FILL (captured with start)
//     src_addr        COPY source byte address (captured with start)
//     dst_addr        destination byte address (captured with start)
//     count           number of vectors to move (captured with start)
//     fill_data       FILL pattern (captured with start)
//     mem_WE/A/WD     memory write enable, byte address, write data
//     mem_RD          memory read data, combinational from mem_A
//     busy            high in READ and WRITE
//     done            one-cycle completion pulse
//     xfer_cnt        vectors written in the current or last job
//     o_dbg_state     FSM state (IDLE=0, READ=1, WRITE=2, DONE=3)
//
//   Handshake: a job is accepted on the rising edge where start=1 and the FSM is
//   in IDLE. Any start seen in another state is dropped, not queued. Completion
//   is signalled by a single-cycle done pulse; no acknowledge is required.
module vect_mem_dma #(
  parameter int LANES     = 6,
  parameter int LANE_W    = 8,
  parameter int CNT_W     = 8,
  parameter int ADDR_STEP = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         mode,
  input  logic [31:0]                  src_addr,
  input  logic [31:0]                  dst_addr,
  input  logic [CNT_W-1:0]             count,
  input  logic [LANES-1:0][LANE_W-1:0] fill_data,
  output logic                         mem_WE,
  output logic [31:0]                  mem_A,
  output logic [LANES-1:0][LANE_W-1:0] mem_WD,
  input  logic [LANES-1:0][LANE_W-1:0] mem_RD,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             xfer_cnt,
  output logic [1:0]                   o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic                           r_mode;
  logic [31:0]                    r_src;
  logic [31:0]                    r_dst;
  logic [CNT_W-1:0]               r_count;
  logic [CNT_W-1:0]               r_xfer_cnt;
  logic [LANES-1:0][LANE_W-1:0]   r_fill;
  logic [LANES-1:0][LANE_W-1:0]   r_buf;
  logic                           w_last;

  localparam logic [31:0]      STEP = 32'(ADDR_STEP);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  // The write in progress is the last one when the post-increment count
  // reaches the requested count.
  assign w_last      = ((r_xfer_cnt + ONE) == r_count);
  assign xfer_cnt    = r_xfer_cnt;
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_src      <= '0;
      r_dst      <= '0;
      r_count    <= '0;
      r_xfer_cnt <= '0;
      r_fill     <= '0;
      r_buf      <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode     <= mode;
            r_src      <= src_addr;
            r_dst      <= dst_addr;
            r_count    <= count;
            r_fill     <= fill_data;
            r_xfer_cnt <= '0;
          end
        end
        S_READ: begin
          r_buf <= mem_RD;
          r_src <= r_src + STEP;
        end
        S_WRITE: begin
          r_dst      <= r_dst + STEP;
          r_xfer_cnt <= r_xfer_cnt + ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    mem_WE       = 1'b0;
    mem_A        = '0;
    mem_WD       = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (count == '0)  w_next_state = S_DONE;
          else if (mode)    w_next_state = S_WRITE;
          else              w_next_state = S_READ;
        end
      end
      S_READ: begin
        busy         = 1'b1;
        mem_A        = r_src;
        w_next_state = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        mem_WE = 1'b1;
        mem_A  = r_dst;
        mem_WD = r_mode ? r_fill : r_buf;
        if (w_last)      w_next_state = S_DONE;
        else if (r_mode) w_next_state = S_WRITE;
        else             w_next_state = S_READ;
      end
      S_DONE: begin
        done         = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vect_mem_dma.sv
// tb_vect_mem_dma
//   Directed bench for vect_mem_dma. The bench holds a 4096-vector memory that
//   is indexed by A[13:2]. It records every write into a log, and each scenario
//   task compares the log, the timing counters and the final memory contents
//   against hand-computed values.
module tb_vect_mem_dma;

  logic             clk;
  logic             rst;
  logic             start;
  logic             mode;
  logic [31:0]      src_addr;
  logic [31:0]      dst_addr;
  logic [7:0]       count;
  logic [5:0][7:0]  fill_data;
  logic             mem_WE;
  logic [31:0]      mem_A;
  logic [5:0][7:0]  mem_WD;
  logic [5:0][7:0]  mem_RD;
  logic             busy;
  logic             done;
  logic [7:0]       xfer_cnt;
  logic [1:0]       o_dbg_state;

  logic [47:0] mem [0:4095];
  logic [79:0] wr_q[$];
  logic [79:0] exp_q[$];

  int n_vec;
  int n_err;
  int done_cyc;
  int n_done;
  int n_we;
  int n_busy;

  localparam logic [47:0] V0 = 48'hA5A5_0000_0001;
  localparam logic [47:0] V1 = 48'h5A5A_1111_0002;
  localparam logic [47:0] V2 = 48'hC3C3_2222_0003;

  vect_mem_dma dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
    .fill_data(fill_data), .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD),
    .mem_RD(mem_RD), .busy(busy), .done(done), .xfer_cnt(xfer_cnt),
    .o_dbg_state(o_dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, write on the rising edge
  assign mem_RD = mem[mem_A[13:2]];
  always @(posedge clk) begin
    if (mem_WE) begin
      mem[mem_A[13:2]] = mem_WD;
      wr_q.push_back({mem_A, 48'(mem_WD)});
    end
  end

  // Drives one job request and returns just after the accepting edge E0.
  task automatic start_job(input logic m, input logic [31:0] s, input logic [31:0] d,
                           input logic [7:0] c, input logic [47:0] f);
    @(negedge clk);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; count = c; fill_data = f;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Samples for `win` cycles after E0. Cycle c is the one after edge E(c).
  // rst_at / restart_at inject reset or a second start from the negedge of that cycle.
  task automatic observe(input int win, input int rst_at, input int restart_at);
    done_cyc = -1; n_done = 0; n_we = 0; n_busy = 0;
    for (int c = 0; c < win; c++) begin
      @(negedge clk);
      if (done) begin
        if (done_cyc < 0) done_cyc = c;
        n_done++;
      end
      if (mem_WE) n_we++;
      if (busy) n_busy++;
      if (c == rst_at) rst = 1'b1;
      if (c == rst_at + 2) rst = 1'b0;
      if (c == restart_at) begin
        start = 1'b1; mode = 1'b1; dst_addr = 32'h200; count = 8'd1;
        fill_data = 48'hFFFF_FFFF_FFFF;
      end
      if (c == restart_at + 1) start = 1'b0;
    end
  endtask

  // Compares the write log against exp_q entry by entry.
  task automatic check_writes(input string name);
    logic [79:0] got;
    n_vec++;
    if (wr_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL %s write count got=%0d exp=%0d", name, wr_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < wr_q.size()) ? wr_q[i] : 'x;
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s write[%0d] got=%h exp=%h", name, i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (mem_WE !== 1'b0) begin n_err++; $display("FAIL reset mem_WE got=%b exp=0", mem_WE); end
    n_vec++; if (mem_A !== 32'h0) begin n_err++; $display("FAIL reset mem_A got=%h exp=0", mem_A); end
    n_vec++; if (mem_WD !== 48'h0) begin n_err++; $display("FAIL reset mem_WD got=%h exp=0", mem_WD); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got=%b exp=0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done got=%b exp=0", done); end
    n_vec++; if (xfer_cnt !== 8'd0) begin n_err++; $display("FAIL reset xfer_cnt got=%0d exp=0", xfer_cnt); end
    n_vec++; if (o_dbg_state !== 2'd0) begin n_err++; $display("FAIL reset state got=%0d exp=0", o_dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_copy;
    mem[0] = V0; mem[1] = V1; mem[2] = V2;
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({32'h40, V0}); exp_q.push_back({32'h44, V1}); exp_q.push_back({32'h48, V2});
    start_job(1'b0, 32'h0, 32'h40, 8'd3, 48'h0);
    observe(12, -1, -1);
    n_vec++; if (done_cyc !== 6) begin n_err++; $display("FAIL copy done_cyc got=%0d exp=6", done_cyc); end
    n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL copy n_done got=%0d exp=1", n_done); end
    n_vec++; if (n_busy !== 6) begin n_err++; $display("FAIL copy busy_cycles got=%0d exp=6", n_busy); end
    n_vec++; if (xfer_cnt !== 8'd3) begin n_err++; $display("FAIL copy xfer_cnt got=%0d exp=3", xfer_cnt); end
    check_writes("copy");
  endtask

  task automatic test_fill;
    wr_q.delete(); exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({32'h100 + 32'(4 * i), 48'h0102_0304_0506});
    start_job(1'b1, 32'h0, 32'h100, 8'd4, 48'h0102_0304_0506);
    observe(10, -1, -1);
    n_vec++; if (done_cyc !== 4) begin n_err++; $display("FAIL fill done_cyc got=%0d exp=4", done_cyc); end
    n_vec++; if (n_we !== 4) begin n_err++; $display("FAIL fill we_cycles got=%0d exp=4", n_we); end
    n_vec++; if (xfer_cnt !== 8'd4) begin n_err++; $display("FAIL fill xfer_cnt got=%0d exp=4", xfer_cnt); end
    check_writes("fill");
  endtask

  task automatic test_zero_count;
    wr_q.delete(); exp_q.delete();
    start_job(1'b0, 32'h0, 32'h300, 8'd0, 48'h0);
    observe(6, -1, -1);
    n_vec++; if (done_cyc !== 0) begin n_err++; $display("FAIL zero done_cyc got=%0d exp=0", done_cyc); end
    n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL zero n_done got=%0d exp=1", n_done); end
    n_vec++; if (n_we !== 0) begin n_err++; $display("FAIL zero we_cycles got=%0d exp=0", n_we); end
    n_vec++; if (n_busy !== 0) begin n_err++; $display("FAIL zero busy_cycles got=%0d exp=0", n_busy); end
    n_vec++; if (xfer_cnt !== 8'd0) begin n_err++; $display("FAIL zero xfer_cnt got=%0d exp=0", xfer_cnt); end
    check_writes("zero");
  endtask

  task automatic test_start_while_busy;
    mem[0] = V0; mem[1] = V1;
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({32'h80, V0}); exp_q.push_back({32'h84, V1});
    start_job(1'b0, 32'h0, 32'h80, 8'd2, 48'h0);
    observe(14, -1, 2);
    n_vec++; if (done_cyc !== 4) begin n_err++; $display("FAIL busy_start done_cyc got=%0d exp=4", done_cyc); end
    n_vec++; if (n_done !== 1) begin n_err++; $display("FAIL busy_start n_done got=%0d exp=1", n_done); end
    n_vec++; if (xfer_cnt !== 8'd2) begin n_err++; $display("FAIL busy_start xfer_cnt got=%0d exp=2", xfer_cnt); end
    check_writes("busy_start");
  endtask

  task automatic test_rst_mid_job;
    mem[0] = V0; mem[1] = V1; mem[2] = V2;
    mem[16] = 48'h0; mem[17] = 48'h0; mem[18] = 48'h0;
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({32'h40, V0});
    start_job(1'b0, 32'h0, 32'h40, 8'd3, 48'h0);
    observe(12, 1, -1);
    n_vec++; if (n_we !== 1) begin n_err++; $display("FAIL rst_mid we_cycles got=%0d exp=1", n_we); end
    n_vec++; if (n_done !== 0) begin n_err++; $display("FAIL rst_mid n_done got=%0d exp=0", n_done); end
    n_vec++; if (mem[16] !== V0) begin n_err++; $display("FAIL rst_mid mem40 got=%h exp=%h", mem[16], V0); end
    n_vec++; if (mem[17] !== 48'h0) begin n_err++; $display("FAIL rst_mid mem44 got=%h exp=0", mem[17]); end
    n_vec++; if (mem[18] !== 48'h0) begin n_err++; $display("FAIL rst_mid mem48 got=%h exp=0", mem[18]); end
    n_vec++; if (xfer_cnt !== 8'd0) begin n_err++; $display("FAIL rst_mid xfer_cnt got=%0d exp=0", xfer_cnt); end
    n_vec++; if (mem_A !== 32'h0) begin n_err++; $display("FAIL rst_mid mem_A got=%h exp=0", mem_A); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid busy got=%b exp=0", busy); end
    check_writes("rst_mid");
  endtask

  task automatic test_overlap_copy;
    mem[0] = V0; mem[1] = V1; mem[2] = V2; mem[3] = 48'h0;
    wr_q.delete(); exp_q.delete();
    for (int i = 1; i <= 3; i++) exp_q.push_back({32'(4 * i), V0});
    start_job(1'b0, 32'h0, 32'h4, 8'd3, 48'h0);
    observe(12, -1, -1);
    n_vec++; if (done_cyc !== 6) begin n_err++; $display("FAIL overlap done_cyc got=%0d exp=6", done_cyc); end
    n_vec++; if (mem[3] !== V0) begin n_err++; $display("FAIL overlap mem0C got=%h exp=%h", mem[3], V0); end
    check_writes("overlap");
  endtask

  task automatic test_addr_wrap;
    wr_q.delete(); exp_q.delete();
    exp_q.push_back({32'hFFFF_FFFE, 48'h1234_5678_9ABC});
    exp_q.push_back({32'h0000_0002, 48'h1234_5678_9ABC});
    start_job(1'b1, 32'h0, 32'hFFFF_FFFE, 8'd2, 48'h1234_5678_9ABC);
    observe(6, -1, -1);
    n_vec++; if (done_cyc !== 2) begin n_err++; $display("FAIL wrap done_cyc got=%0d exp=2", done_cyc); end
    check_writes("wrap");
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
    count = '0; fill_data = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 48'h0;
    test_reset();
    test_copy();
    test_fill();
    test_zero_count();
    test_start_while_busy();
    test_rst_mid_job();
    test_overlap_copy();
    test_addr_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
